// File: rtl/ifetch.sv
// Instruction fetch unit: PC, one fetch per cycle into a shift-register FIFO, valid/ready to decode.
// Optional macro IFETCH_MISALIGN_TRAP_EN adds a FAULT state for misaligned redirect targets.
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst_data,
  output logic [31:0] o_inst_pc,
  output logic        o_fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]           r_pc;
  logic [31:0]           w_pcNext;
  logic [31:0]           w_target;
  logic [FIFO_DEPTH-1:0] r_valid;
  logic [FIFO_DEPTH-1:0] w_validNext;
  logic [31:0]           r_slotPc     [FIFO_DEPTH];
  logic [31:0]           w_slotPcNext [FIFO_DEPTH];
  logic [31:0]           r_slotData     [FIFO_DEPTH];
  logic [31:0]           w_slotDataNext [FIFO_DEPTH];
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_countNext;
  logic [CW-1:0]         w_tailIdx;
  logic                  w_run;
  logic                  w_pop;
  logic                  w_push;

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetchState_t;

  fetchState_t r_state;
  fetchState_t w_stateNext;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Every redirect re-decides the state from target alignment, including from FAULT.
  always_comb begin
    w_stateNext = r_state;
    if (i_redirect_valid) begin
      w_stateNext = (i_redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_FAULT;
    end
  end

  always_comb begin
    w_run         = (r_state == ST_RUN);
    o_fetch_fault = (r_state == ST_FAULT);
  end

  assign w_target = i_redirect_pc;
`else
  assign w_run         = 1'b1;
  assign o_fetch_fault = 1'b0;
  assign w_target      = i_redirect_pc & 32'hFFFF_FFFC;
`endif

  // Slot 0 is the head, so the decode-facing outputs come straight from flops.
  always_comb begin
    w_pop          = r_valid[0] & i_inst_ready;
    w_push         = w_run & ~i_redirect_valid & (~r_valid[FIFO_DEPTH-1] | w_pop);
    w_tailIdx      = r_count - CW'(w_pop);
    w_validNext    = r_valid;
    w_slotPcNext   = r_slotPc;
    w_slotDataNext = r_slotData;

    if (w_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        w_validNext[i]    = r_valid[i+1];
        w_slotPcNext[i]   = r_slotPc[i+1];
        w_slotDataNext[i] = r_slotData[i+1];
      end
      w_validNext[FIFO_DEPTH-1]    = 1'b0;
      w_slotPcNext[FIFO_DEPTH-1]   = '0;
      w_slotDataNext[FIFO_DEPTH-1] = '0;
    end

    if (w_push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_tailIdx == CW'(i)) begin
          w_validNext[i]    = 1'b1;
          w_slotPcNext[i]   = r_pc;
          w_slotDataNext[i] = i_imem_rdata;
        end
      end
    end

    w_countNext = r_count + CW'(w_push) - CW'(w_pop);
    w_pcNext    = w_push ? (r_pc + 32'd4) : r_pc;

    // A redirect wins over everything; a same-cycle pop is acknowledged but its entry is dropped.
    if (i_redirect_valid) begin
      w_validNext = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        w_slotPcNext[i]   = '0;
        w_slotDataNext[i] = '0;
      end
      w_countNext = '0;
      w_pcNext    = w_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_slotPc[i]   <= '0;
        r_slotData[i] <= '0;
      end
    end else begin
      r_pc       <= w_pcNext;
      r_count    <= w_countNext;
      r_valid    <= w_validNext;
      r_slotPc   <= w_slotPcNext;
      r_slotData <= w_slotDataNext;
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_inst_valid = r_valid[0];
  assign o_inst_pc    = r_slotPc[0];
  assign o_inst_data  = r_slotData[0];

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch (RESET_PC=0x100, FIFO_DEPTH=2).
// Memory returns 0x1000_0000 + (addr >> 2) for every word address.
module tb_ifetch;

  logic        clk;
  logic        rstN;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        instValid;
  logic        instReady;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        fetchFault;

  int checkCount;
  int errCount;

  ifetch #(
    .RESET_PC  (32'h0000_0100),
    .FIFO_DEPTH(2)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .o_imem_addr     (imemAddr),
    .i_imem_rdata    (imemRdata),
    .i_redirect_valid(redirectValid),
    .i_redirect_pc   (redirectPc),
    .o_inst_valid    (instValid),
    .i_inst_ready    (instReady),
    .o_inst_data     (instData),
    .o_inst_pc       (instPc),
    .o_fetch_fault   (fetchFault)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory with ascending contents.
  always_comb imemRdata = 32'h1000_0000 + (imemAddr >> 2);

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] target,
                               input logic ready);
    rstN          = rst;
    redirectValid = redir;
    redirectPc    = target;
    instReady     = ready;
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] data);
    checkOutput({tag, "_valid"}, {31'd0, instValid}, 32'd1);
    checkOutput({tag, "_pc"}, instPc, pc);
    checkOutput({tag, "_data"}, instData, data);
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, instValid}, 32'd0);
    checkOutput({tag, "_pc"}, instPc, 32'd0);
    checkOutput({tag, "_data"}, instData, 32'd0);
  endtask

  initial begin
    checkCount = 0;
    errCount   = 0;

    // Reset and sequential fetch from RESET_PC with decode always ready.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("rst_addr", imemAddr, 32'h0000_0100);
    checkEmpty("rst_head");
    checkOutput("rst_fault", {31'd0, fetchFault}, 32'd0);
    stepCycle();
    checkHead("seq0", 32'h0000_0100, 32'h1000_0040);
    stepCycle();
    checkHead("seq1", 32'h0000_0104, 32'h1000_0041);
    stepCycle();
    checkHead("seq2", 32'h0000_0108, 32'h1000_0042);

    // Backpressure: FIFO fills to two, PC freezes at head+8.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("bp_addr2", imemAddr, 32'h0000_0110);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("bp_addr5", imemAddr, 32'h0000_0110);
    checkHead("bp_hold", 32'h0000_0108, 32'h1000_0042);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    stepCycle();
    checkHead("bp_rel0", 32'h0000_010C, 32'h1000_0043);
    stepCycle();
    checkHead("bp_rel1", 32'h0000_0110, 32'h1000_0044);
    stepCycle();
    checkHead("bp_rel2", 32'h0000_0114, 32'h1000_0045);
    checkOutput("bp_rel2_addr", imemAddr, 32'h0000_011C);

    // Redirect to 0x200 while two entries (0x114, 0x118) are queued.
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkEmpty("rd_flush");
    checkOutput("rd_addr", imemAddr, 32'h0000_0200);
    stepCycle();
    checkHead("rd_head0", 32'h0000_0200, 32'h1000_0080);
    stepCycle();
    checkHead("rd_head1", 32'h0000_0204, 32'h1000_0081);

    // Wrap-around from the top of the address space.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkEmpty("wr_flush");
    checkOutput("wr_addr", imemAddr, 32'hFFFF_FFFC);
    stepCycle();
    checkHead("wr_head0", 32'hFFFF_FFFC, 32'h4FFF_FFFF);
    stepCycle();
    checkHead("wr_head1", 32'h0000_0000, 32'h1000_0000);
    checkOutput("wr_addr1", imemAddr, 32'h0000_0004);

    // Misaligned redirect to 0x302, then an aligned redirect to 0x400.
    applyStimulus(1'b1, 1'b1, 32'h0000_0302, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkEmpty("mis_flush");
`ifdef IFETCH_MISALIGN_TRAP_EN
    checkOutput("mis_fault0", {31'd0, fetchFault}, 32'd1);
    checkOutput("mis_addr0", imemAddr, 32'h0000_0302);
    stepCycle();
    checkEmpty("mis_stay");
    checkOutput("mis_fault1", {31'd0, fetchFault}, 32'd1);
    checkOutput("mis_addr1", imemAddr, 32'h0000_0302);
`else
    checkOutput("mis_fault0", {31'd0, fetchFault}, 32'd0);
    checkOutput("mis_addr0", imemAddr, 32'h0000_0300);
    stepCycle();
    checkHead("mis_head", 32'h0000_0300, 32'h1000_00C0);
    checkOutput("mis_fault1", {31'd0, fetchFault}, 32'd0);
`endif
    applyStimulus(1'b1, 1'b1, 32'h0000_0400, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkEmpty("rec_flush");
    checkOutput("rec_fault", {31'd0, fetchFault}, 32'd0);
    checkOutput("rec_addr", imemAddr, 32'h0000_0400);
    stepCycle();
    checkHead("rec_head", 32'h0000_0400, 32'h1000_0100);

    // One-cycle reset mid-stream with a competing redirect.
    applyStimulus(1'b0, 1'b1, 32'h0000_0500, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkEmpty("mrst_head");
    checkOutput("mrst_fault", {31'd0, fetchFault}, 32'd0);
    checkOutput("mrst_addr", imemAddr, 32'h0000_0100);
    stepCycle();
    checkHead("mrst_head0", 32'h0000_0100, 32'h1000_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, errCount);
    $finish;
  end

endmodule
